lsu: RTL and testbench

- Load/store unit between the execute stage and writeback.
- Takes the ALU-computed effective address plus opcode/funct3 for RV32I loads and stores.
- Runs a request/grant/response transaction on the data-memory port and returns a sign- or zero-extended load result to writeback as load_out, with rd passed through.
- Detects misaligned and unsupported accesses without touching memory, and times out on a stuck memory.

---
 rtl/lsu.sv | 226 ++++++++++++++++++++++
 tb/tb_lsu.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/lsu.sv
// RV32I load/store unit: request/grant/response sequencing on the data-memory port,
// lane steering for stores, lane extraction and extension for loads, fault detection.
module lsu #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] st_data,
  input  logic [4:0]  rd_i,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        out_valid,
  output logic [31:0] load_out,
  output logic [4:0]  rd_o,
  output logic [1:0]  fault
);

  localparam logic [6:0]       OP_LOAD  = 7'b0000011;
  localparam logic [6:0]       OP_STORE = 7'b0100011;
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] FLT_OK  = 2'b00;
  localparam logic [1:0] FLT_MIS = 2'b01;
  localparam logic [1:0] FLT_F3  = 2'b10;
  localparam logic [1:0] FLT_TO  = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT_R, S_DONE} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_is_ld;
  logic [2:0]       r_f3;
  logic [1:0]       r_addr_lo;
  logic [4:0]       r_rd;
  logic [31:0]      r_ld_val;
  logic [1:0]       r_flt;

  logic             r_in_ready;
  logic             r_mem_req;
  logic             r_mem_we;
  logic [31:0]      r_mem_addr;
  logic [31:0]      r_mem_wdata;
  logic [3:0]       r_mem_wstrb;
  logic             r_out_valid;
  logic [31:0]      r_load_out;
  logic [4:0]       r_rd_o;
  logic [1:0]       r_fault;

  logic             w_is_ld;
  logic             w_is_st;
  logic             w_accept;
  logic             w_bad_f3;
  logic             w_mis;
  logic [31:0]      w_wdata;
  logic [3:0]       w_wstrb;
  logic [7:0]       w_byte;
  logic [15:0]      w_half;
  logic [31:0]      w_ld_ext;

  assign w_is_ld  = (opcode == OP_LOAD);
  assign w_is_st  = (opcode == OP_STORE);
  assign w_accept = in_valid & r_in_ready & (w_is_ld | w_is_st);
  assign w_mis    = ((funct3[1:0] == 2'b01) & addr[0]) |
                    ((funct3[1:0] == 2'b10) & (addr[1:0] != 2'b00));

  // Legal size/sign encodings differ between loads and stores
  always_comb begin
    w_bad_f3 = 1'b1;
    if (w_is_ld) begin
      case (funct3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_bad_f3 = 1'b0;
        default:                                w_bad_f3 = 1'b1;
      endcase
    end else begin
      case (funct3)
        3'b000, 3'b001, 3'b010: w_bad_f3 = 1'b0;
        default:                w_bad_f3 = 1'b1;
      endcase
    end
  end

  // Store data is replicated across lanes; byte enables pick the target lanes
  always_comb begin
    w_wdata = st_data;
    w_wstrb = 4'b1111;
    case (funct3[1:0])
      2'b00: begin
        w_wdata = {4{st_data[7:0]}};
        w_wstrb = 4'b0001 << addr[1:0];
      end
      2'b01: begin
        w_wdata = {2{st_data[15:0]}};
        w_wstrb = addr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        w_wdata = st_data;
        w_wstrb = 4'b1111;
      end
    endcase
  end

  assign w_byte = mem_rdata[{r_addr_lo, 3'b000} +: 8];
  assign w_half = r_addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    w_ld_ext = mem_rdata;
    case (r_f3)
      3'b000:  w_ld_ext = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_ld_ext = {{16{w_half[15]}}, w_half};
      3'b100:  w_ld_ext = {24'h000000, w_byte};
      3'b101:  w_ld_ext = {16'h0000, w_half};
      default: w_ld_ext = mem_rdata;
    endcase
  end

  // Transaction FSM; completion results are published only when leaving DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_is_ld     <= 1'b0;
      r_f3        <= 3'b000;
      r_addr_lo   <= 2'b00;
      r_rd        <= 5'd0;
      r_ld_val    <= 32'd0;
      r_flt       <= FLT_OK;
      r_in_ready  <= 1'b1;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 32'd0;
      r_mem_wdata <= 32'd0;
      r_mem_wstrb <= 4'b0000;
      r_out_valid <= 1'b0;
      r_load_out  <= 32'd0;
      r_rd_o      <= 5'd0;
      r_fault     <= FLT_OK;
    end else begin
      r_out_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_in_ready <= 1'b0;
            r_is_ld    <= w_is_ld;
            r_f3       <= funct3;
            r_addr_lo  <= addr[1:0];
            r_rd       <= rd_i;
            r_ld_val   <= 32'd0;
            r_cnt      <= '0;
            if (w_bad_f3) begin
              r_flt   <= FLT_F3;
              r_state <= S_DONE;
            end else if (w_mis) begin
              r_flt   <= FLT_MIS;
              r_state <= S_DONE;
            end else begin
              r_flt       <= FLT_OK;
              r_state     <= S_REQ;
              r_mem_req   <= 1'b1;
              r_mem_we    <= w_is_st;
              r_mem_addr  <= {addr[31:2], 2'b00};
              r_mem_wdata <= w_is_st ? w_wdata : 32'd0;
              r_mem_wstrb <= w_is_st ? w_wstrb : 4'b0000;
            end
          end
        end
        S_REQ: begin
          if (mem_gnt) begin
            r_mem_req <= 1'b0;
            r_cnt     <= '0;
            r_state   <= r_is_ld ? S_WAIT_R : S_DONE;
          end else if (r_cnt == TO_LAST) begin
            r_mem_req <= 1'b0;
            r_flt     <= FLT_TO;
            r_state   <= S_DONE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_WAIT_R: begin
          if (mem_rvalid) begin
            r_ld_val <= w_ld_ext;
            r_state  <= S_DONE;
          end else if (r_cnt == TO_LAST) begin
            r_flt   <= FLT_TO;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_DONE: begin
          r_out_valid <= 1'b1;
          r_load_out  <= r_ld_val;
          r_rd_o      <= r_rd;
          r_fault     <= r_flt;
          r_in_ready  <= 1'b1;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_wstrb = r_mem_wstrb;
  assign out_valid = r_out_valid;
  assign load_out  = r_load_out;
  assign rd_o      = r_rd_o;
  assign fault     = r_fault;

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu: directed ops push expected completions, a negedge monitor checks them.
module tb_lsu;

  localparam logic [6:0] LD = 7'b0000011;
  localparam logic [6:0] ST = 7'b0100011;
  localparam int NEVER = 1000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] st_data;
  logic [4:0]  rd_i;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        out_valid;
  logic [31:0] load_out;
  logic [4:0]  rd_o;
  logic [1:0]  fault;

  lsu #(.TIMEOUT(16), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .funct3(funct3), .addr(addr), .st_data(st_data), .rd_i(rd_i),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .out_valid(out_valid), .load_out(load_out),
    .rd_o(rd_o), .fault(fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] ld;
    logic [1:0]  flt;
    int          cyc;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every completion pulse must match the oldest expectation
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_out_valid", 32'd1, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        chk("rd_o", 32'(rd_o), 32'(mon_e.rd));
        chk("load_out", load_out, mon_e.ld);
        chk("fault", 32'(fault), 32'(mon_e.flt));
        chk("latency_cycle", 32'(cyc), 32'(mon_e.cyc));
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) chk("in_ready_wait", 32'(in_ready), 32'd1);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    if (sb_q.size() != 0) begin
      chk("completion_timeout", 32'(sb_q.size()), 32'd0);
      sb_q.delete();
    end
  endtask

  // gd/rv: cycles of gnt/rvalid delay (NEVER = not delivered); lat: accept-to-out_valid cycles
  task automatic do_op(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, input logic [4:0] rd, input int gd, input int rv,
                       input logic [31:0] rdat, input logic [31:0] eload, input logic [1:0] eflt,
                       input int elat, input logic [3:0] estrb, input logic [31:0] ewdata);
    exp_t e;
    wait_ready();
    opcode = op; funct3 = f3; addr = a; st_data = d; rd_i = rd; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    e.rd = rd; e.ld = eload; e.flt = eflt; e.cyc = cyc + elat - 1;
    sb_q.push_back(e);
    if (eflt == 2'b01 || eflt == 2'b10) begin
      chk("no_mem_req_on_fault", 32'(mem_req), 32'd0);
    end else begin
      chk("mem_req", 32'(mem_req), 32'd1);
      chk("mem_addr", mem_addr, {a[31:2], 2'b00});
      chk("mem_we", 32'(mem_we), 32'(op == ST));
      if (op == ST) begin
        chk("mem_wstrb", 32'(mem_wstrb), 32'(estrb));
        chk("mem_wdata", mem_wdata, ewdata);
      end
      if (gd < NEVER) begin
        repeat (gd) begin @(posedge clk); #1; end
        chk("mem_req_held", 32'(mem_req), 32'd1);
        mem_gnt = 1'b1;
        @(posedge clk); #1;
        mem_gnt = 1'b0;
        chk("mem_req_after_gnt", 32'(mem_req), 32'd0);
        if (op == LD && rv < NEVER) begin
          repeat (rv) begin @(posedge clk); #1; end
          mem_rvalid = 1'b1; mem_rdata = rdat;
          @(posedge clk); #1;
          mem_rvalid = 1'b0; mem_rdata = 32'd0;
        end
      end
    end
    wait_drain();
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; opcode = 7'd0; funct3 = 3'd0; addr = 32'd0;
    st_data = 32'd0; rd_i = 5'd0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_load_out", load_out, 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Stores
    do_op(ST, 3'b010, 32'h104, 32'hDEADBEEF, 5'd5, 0, 0, 0, 32'd0, 2'b00, 3, 4'b1111, 32'hDEADBEEF);
    do_op(ST, 3'b000, 32'h203, 32'h000000A5, 5'd6, 2, 0, 0, 32'd0, 2'b00, 5, 4'b1000, 32'hA5A5A5A5);
    do_op(ST, 3'b001, 32'h202, 32'h00001234, 5'd8, 0, 0, 0, 32'd0, 2'b00, 3, 4'b1100, 32'h12341234);
    // Loads
    do_op(LD, 3'b000, 32'h101, 32'd0, 5'd7, 0, 1, 32'h000080FF, 32'hFFFFFF80, 2'b00, 5, 4'b0, 32'd0);
    do_op(LD, 3'b100, 32'h101, 32'd0, 5'd10, 0, 1, 32'h000080FF, 32'h00000080, 2'b00, 5, 4'b0, 32'd0);
    do_op(LD, 3'b101, 32'h102, 32'd0, 5'd12, 0, 0, 32'hBEEF0000, 32'h0000BEEF, 2'b00, 4, 4'b0, 32'd0);
    do_op(LD, 3'b001, 32'h100, 32'd0, 5'd13, 1, 0, 32'h00008001, 32'hFFFF8001, 2'b00, 5, 4'b0, 32'd0);
    do_op(LD, 3'b010, 32'h200, 32'd0, 5'd14, 0, 0, 32'h12345678, 32'h12345678, 2'b00, 4, 4'b0, 32'd0);
    // Faults without memory traffic
    do_op(LD, 3'b010, 32'h102, 32'd0, 5'd15, 0, 0, 0, 32'd0, 2'b01, 2, 4'b0, 32'd0);
    do_op(LD, 3'b011, 32'h100, 32'd0, 5'd16, 0, 0, 0, 32'd0, 2'b10, 2, 4'b0, 32'd0);
    do_op(ST, 3'b011, 32'h101, 32'd0, 5'd17, 0, 0, 0, 32'd0, 2'b10, 2, 4'b0, 32'd0);
    do_op(LD, 3'b001, 32'h103, 32'd0, 5'd18, 0, 0, 0, 32'd0, 2'b01, 2, 4'b0, 32'd0);

    // Non-memory opcode is not accepted
    opcode = 7'b0110011; funct3 = 3'b010; addr = 32'h100; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("nonmem_in_ready", 32'(in_ready), 32'd1);
    chk("nonmem_mem_req", 32'(mem_req), 32'd0);

    // Timeouts: stuck grant, then stuck read data
    do_op(ST, 3'b010, 32'h300, 32'h11111111, 5'd19, NEVER, 0, 0, 32'd0, 2'b11, 18, 4'b1111, 32'h11111111);
    do_op(LD, 3'b010, 32'h300, 32'd0, 5'd9, 0, NEVER, 0, 32'd0, 2'b11, 19, 4'b0, 32'd0);
    mem_rvalid = 1'b1; mem_rdata = 32'h55555555;
    @(posedge clk); #1;
    mem_rvalid = 1'b0; mem_rdata = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    do_op(LD, 3'b010, 32'h500, 32'd0, 5'd11, 0, 0, 32'hCAFEF00D, 32'hCAFEF00D, 2'b00, 4, 4'b0, 32'd0);

    // Asynchronous reset in the middle of a request
    wait_ready();
    opcode = LD; funct3 = 3'b010; addr = 32'h400; rd_i = 5'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("pre_rst_mem_req", 32'(mem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_mem_req", 32'(mem_req), 32'd0);
    chk("async_rst_in_ready", 32'(in_ready), 32'd1);
    chk("async_rst_load_out", load_out, 32'd0);
    chk("async_rst_rd_o", 32'(rd_o), 32'd0);
    chk("async_rst_mem_addr", mem_addr, 32'd0);
    @(posedge clk); #1;
    mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h77777777;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    chk("post_rst_mem_req", 32'(mem_req), 32'd0);
    do_op(LD, 3'b000, 32'h103, 32'd0, 5'd21, 0, 0, 32'h7F000000, 32'h0000007F, 2'b00, 4, 4'b0, 32'd0);

    repeat (4) @(posedge clk);
    #1;
    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
